// File: rtl/sum_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_ctrl_pkg
// Brief    : Shared types and constants for the sum(1..LIMIT) control unit:
//            FSM state encoding, ALU opcodes, register-file map, mux selects.
// Revision : 1.0 - initial release
// ============================================================================
package sum_ctrl_pkg;

    // Control-unit states; 4-bit encoding leaves five unused codes that the
    // FSM steers back to IDLE.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT_I    = 4'd1,
        S_INIT_S    = 4'd2,
        S_INIT_ONE  = 4'd3,
        S_INIT_LIM  = 4'd4,
        S_BUILD_LIM = 4'd5,
        S_CMP       = 4'd6,
        S_INC_I     = 4'd7,
        S_ACC       = 4'd8,
        S_OUT       = 4'd9,
        S_DONE      = 4'd10
    } state_t;

    // ALU operation codes understood by the datapath
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Register-file map used by the sum algorithm
    localparam logic [2:0] REG_ZERO = 3'd0;  // hardwired zero
    localparam logic [2:0] REG_I    = 3'd1;  // loop index i
    localparam logic [2:0] REG_SUM  = 3'd2;  // running sum
    localparam logic [2:0] REG_ONE  = 3'd3;  // constant one
    localparam logic [2:0] REG_LIM  = 3'd4;  // LIMIT, built by repeated +1

    // Register-file write-data source select
    localparam logic MUX_ALU = 1'b0;
    localparam logic MUX_ONE = 1'b1;

endpackage : sum_ctrl_pkg
`default_nettype wire

// File: rtl/sum_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : sum_ctrl_unit
// Brief    : Moore control FSM that sequences an 8-bit register-file/ALU
//            datapath to compute sum(1..LIMIT), load it into the datapath
//            OutPort register and pulse done. The only feedback from the
//            datapath is the unsigned lt comparator output.
// Revision : 1.0 - initial release
// ============================================================================
module sum_ctrl_unit
    import sum_ctrl_pkg::*;
#(
    parameter int LIMIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       lt,
    output logic       RF_Src_Mux_Sel,
    output logic [2:0] r_addr_1,
    output logic [2:0] r_addr_2,
    output logic [2:0] wr_addr,
    output logic       wr_en,
    output logic [1:0] opcode,
    output logic       outport_en,
    output logic       busy,
    output logic       done
);

    // LIMIT above 22 would overflow the 8-bit sum; zero makes no sense
    generate
        if (LIMIT < 1 || LIMIT > 22) begin : g_bad_limit
            $error("sum_ctrl_unit: LIMIT must be in 1..22");
        end
    endgenerate

    localparam int              CNT_W    = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    // State and limit-build counter registers; reset parks the FSM in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and Moore output decode from the current state
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        RF_Src_Mux_Sel = MUX_ALU;
        r_addr_1       = REG_ZERO;
        r_addr_2       = REG_ZERO;
        wr_addr        = REG_ZERO;
        wr_en          = 1'b0;
        opcode         = OP_ADD;
        outport_en     = 1'b0;
        busy           = (state_q != S_IDLE);
        done           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT_I;
                end
            end
            S_INIT_I: begin
                // i = 0 + 0
                wr_addr = REG_I;
                wr_en   = 1'b1;
                state_d = S_INIT_S;
            end
            S_INIT_S: begin
                // sum = 0 + 0
                wr_addr = REG_SUM;
                wr_en   = 1'b1;
                state_d = S_INIT_ONE;
            end
            S_INIT_ONE: begin
                // one = constant 1 through the write mux
                RF_Src_Mux_Sel = MUX_ONE;
                wr_addr        = REG_ONE;
                wr_en          = 1'b1;
                state_d        = S_INIT_ONE == state_q ? S_INIT_LIM : S_IDLE;
            end
            S_INIT_LIM: begin
                // lim = 0 + 0, then grown to LIMIT one step at a time
                wr_addr = REG_LIM;
                wr_en   = 1'b1;
                cnt_d   = '0;
                state_d = S_BUILD_LIM;
            end
            S_BUILD_LIM: begin
                // lim = lim + one, LIMIT times; counter stops at LIMIT-1
                r_addr_1 = REG_LIM;
                r_addr_2 = REG_ONE;
                wr_addr  = REG_LIM;
                wr_en    = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CMP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CMP: begin
                // Datapath reports i < lim on lt
                r_addr_1 = REG_I;
                r_addr_2 = REG_LIM;
                state_d  = lt ? S_INC_I : S_OUT;
            end
            S_INC_I: begin
                // i = i + one
                r_addr_1 = REG_I;
                r_addr_2 = REG_ONE;
                wr_addr  = REG_I;
                wr_en    = 1'b1;
                state_d  = S_ACC;
            end
            S_ACC: begin
                // sum = sum + i
                r_addr_1 = REG_SUM;
                r_addr_2 = REG_I;
                wr_addr  = REG_SUM;
                wr_en    = 1'b1;
                state_d  = S_CMP;
            end
            S_OUT: begin
                // OutPort sources read port 1
                r_addr_1   = REG_SUM;
                outport_en = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule : sum_ctrl_unit
`default_nettype wire

// File: tb/tb_sum_ctrl_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sum_ctrl_unit
// Brief    : Bench for sum_ctrl_unit. Three instances (LIMIT 10, 1, 22) each
//            drive a behavioural register-file/ALU/OutPort datapath. Expected
//            done cycle, sum and register-write trace are queued at stimulus
//            time and compared when done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_ctrl_unit;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start      [NDUT];
    logic       lt         [NDUT];
    logic       mux_sel    [NDUT];
    logic [2:0] ra1        [NDUT];
    logic [2:0] ra2        [NDUT];
    logic [2:0] wa         [NDUT];
    logic       wr_en      [NDUT];
    logic [1:0] opc        [NDUT];
    logic       outport_en [NDUT];
    logic       busy       [NDUT];
    logic       done       [NDUT];

    logic [7:0] rf      [NDUT][8];
    logic [7:0] d1      [NDUT];
    logic [7:0] d2      [NDUT];
    logic [7:0] alu     [NDUT];
    logic [7:0] outport [NDUT];

    typedef struct {
        int         cyc;
        logic [7:0] sum;
    } exp_t;

    exp_t sb     [$];
    int   exp_tr [$];
    int   obs_tr [$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    sum_ctrl_unit #(.LIMIT(10)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .lt(lt[0]),
        .RF_Src_Mux_Sel(mux_sel[0]), .r_addr_1(ra1[0]), .r_addr_2(ra2[0]),
        .wr_addr(wa[0]), .wr_en(wr_en[0]), .opcode(opc[0]),
        .outport_en(outport_en[0]), .busy(busy[0]), .done(done[0])
    );
    sum_ctrl_unit #(.LIMIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .lt(lt[1]),
        .RF_Src_Mux_Sel(mux_sel[1]), .r_addr_1(ra1[1]), .r_addr_2(ra2[1]),
        .wr_addr(wa[1]), .wr_en(wr_en[1]), .opcode(opc[1]),
        .outport_en(outport_en[1]), .busy(busy[1]), .done(done[1])
    );
    sum_ctrl_unit #(.LIMIT(22)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .lt(lt[2]),
        .RF_Src_Mux_Sel(mux_sel[2]), .r_addr_1(ra1[2]), .r_addr_2(ra2[2]),
        .wr_addr(wa[2]), .wr_en(wr_en[2]), .opcode(opc[2]),
        .outport_en(outport_en[2]), .busy(busy[2]), .done(done[2])
    );

    // Datapath read ports, ALU and comparator
    always_comb begin
        for (int k = 0; k < NDUT; k++) begin
            d1[k] = (ra1[k] == 3'd0) ? 8'h00 : rf[k][ra1[k]];
            d2[k] = (ra2[k] == 3'd0) ? 8'h00 : rf[k][ra2[k]];
            case (opc[k])
                2'b00:   alu[k] = d1[k] + d2[k];
                2'b01:   alu[k] = d1[k] - d2[k];
                2'b10:   alu[k] = d1[k] & d2[k];
                default: alu[k] = d1[k] | d2[k];
            endcase
            lt[k] = (d1[k] < d2[k]);
        end
    end

    // Register file write port (not reset)
    always_ff @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (wr_en[k] && wa[k] != 3'd0) begin
                rf[k][wa[k]] <= mux_sel[k] ? 8'd1 : alu[k];
            end
        end
    end

    // OutPort register
    always_ff @(posedge clk or posedge rst) begin
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                outport[k] <= 8'h00;
            end else if (outport_en[k]) begin
                outport[k] <= d1[k];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Per-cycle monitor: write trace capture, busy check, scoreboard pop on done
    task automatic sample(input int k, input int period);
        int bad;
        exp_t e;
        if (wr_en[k] === 1'b1) obs_tr.push_back(int'(wa[k]));
        chk("busy", busy[k], ((cyc % period) != 0) ? 1 : 0);
        if (done[k] === 1'b1) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", done[k], 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("outport", outport[k], e.sum);
                bad = -1;
                if (obs_tr.size() != exp_tr.size()) begin
                    bad = -2;
                end else begin
                    for (int i = exp_tr.size() - 1; i >= 0; i--)
                        if (obs_tr[i] != exp_tr[i]) bad = i;
                end
                chk("wr_trace", bad, -1);
            end
            obs_tr.delete();
        end
    endtask

    task automatic run(input int k, input int lim, input int nruns,
                       input bit hold, input bit extra);
        int period;
        exp_t e;
        period = 4 * lim + 8;
        exp_tr.delete();
        obs_tr.delete();
        exp_tr.push_back(1); exp_tr.push_back(2);
        exp_tr.push_back(3); exp_tr.push_back(4);
        for (int i = 0; i < lim; i++) exp_tr.push_back(4);
        for (int i = 0; i < lim; i++) begin
            exp_tr.push_back(1);
            exp_tr.push_back(2);
        end
        for (int r = 0; r < nruns; r++) begin
            e.cyc = r * period + 4 * lim + 7;
            e.sum = 8'(lim * (lim + 1) / 2);
            sb.push_back(e);
        end
        start[k] = 1'b1;
        cyc      = 0;
        repeat (nruns * period - 1) begin
            step();
            sample(k, period);
            if (!hold) start[k] = extra && (cyc == 5 || cyc == 20);
        end
        start[k] = 1'b0;
        repeat (4) begin
            step();
            chk("idle_busy", busy[k], 0);
            chk("idle_done", done[k], 0);
        end
        chk("missing_done", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) start[k] = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("reset_outputs",
                {mux_sel[k], ra1[k], ra2[k], wa[k], wr_en[k], opc[k],
                 outport_en[k], busy[k], done[k]}, 0);
            chk("reset_outport", outport[k], 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic run, then the LIMIT boundaries
        run(0, 10, 1, 1'b0, 1'b0);
        run(1, 1,  1, 1'b0, 1'b0);
        run(2, 22, 1, 1'b0, 1'b0);

        // Extra start pulses while busy are ignored
        run(0, 10, 1, 1'b0, 1'b1);

        // Reset in the middle of the loop
        start[0] = 1'b1;
        cyc      = 0;
        repeat (30) begin
            step();
            if (cyc == 1) start[0] = 1'b0;
            chk("pre_rst_busy", busy[0], 1);
            chk("pre_rst_done", done[0], 0);
        end
        rst = 1'b1;
        #1;
        chk("midrun_rst_outputs",
            {mux_sel[0], ra1[0], ra2[0], wa[0], wr_en[0], opc[0],
             outport_en[0], busy[0], done[0]}, 0);
        chk("midrun_rst_outport", outport[0], 0);
        @(negedge clk);
        rst = 1'b0;
        run(0, 10, 1, 1'b0, 1'b0);

        // start held high: three back-to-back runs
        run(0, 10, 3, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sum_ctrl_unit
`default_nettype wire
